// File: rtl/if_stage.sv
// ---------------------------------------------------------------------------
// if_stage -- instruction fetch stage with PC generation and IF/ID register
//
// Purpose:
//   Generates the fetch address for a combinational instruction ROM, keeps a
//   one-entry pending-branch register for branches resolved while the PC is
//   stalled, and owns the IF/ID pipeline register. Branches have one delay
//   slot: the instruction fetched in the cycle branch_flag is high still
//   enters IF/ID.
//
// Optional feature (macro IF_ALIGN_CHECK_EN):
//   When defined, a capture from a misaligned pc (pc[1:0] != 0) loads a
//   poisoned IF/ID entry (id_inst=0, id_excp=1, id_valid=1, id_pc=pc). The
//   PC keeps advancing, and the downstream exception logic redirects via
//   flush. When undefined, id_excp is tied to 0 and pc[1:0] is ignored.
//
// Parameters:
//   RESET_PC      first fetch address after reset
//
// Ports:
//   clk           clock, all state updates on the rising edge
//   rst           asynchronous active-low reset
//   stall_pc      hold the PC (IF stalled)
//   stall_id      hold the IF/ID register (ID stalled)
//   flush         exception/eret redirect, highest priority
//   new_pc        redirect address used when flush=1
//   branch_flag   ID resolved a taken branch
//   branch_target taken-branch address
//   pc            fetch address to the instruction ROM
//   rom_ce        ROM chip enable, registered, 1 = enabled
//   rom_inst      combinational ROM data for the current pc
//   id_pc         PC of the instruction in IF/ID
//   id_inst       instruction word in IF/ID
//   id_valid      IF/ID holds a real instruction
//   id_excp       fetch address error flag
//
// Stall/flush semantics (the only flow control this stage has):
//   flush wins over everything and always bubbles IF/ID. Otherwise, when
//   stall_pc=0 the current (pc, rom_inst) pair is accepted into IF/ID and the
//   PC advances. When stall_pc=1 the PC holds; IF/ID holds if stall_id=1,
//   otherwise it is loaded with a bubble so the held fetch is not issued
//   twice.
// ---------------------------------------------------------------------------
module if_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall_pc,
   input  logic        stall_id,
   input  logic        flush,
   input  logic [31:0] new_pc,
   input  logic        branch_flag,
   input  logic [31:0] branch_target,
   output logic [31:0] pc,
   output logic        rom_ce,
   input  logic [31:0] rom_inst,
   output logic [31:0] id_pc,
   output logic [31:0] id_inst,
   output logic        id_valid,
   output logic        id_excp
);

   // ------------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------------
   logic [31:0] pc_q;
   logic        rom_ce_q;
   logic        pend_valid_q;
   logic [31:0] pend_target_q;

   logic [31:0] id_pc_q;
   logic [31:0] id_inst_q;
   logic        id_valid_q;

   // Next-state values
   logic [31:0] pc_d;
   logic        pend_valid_d;
   logic [31:0] pend_target_d;
   logic [31:0] id_pc_d;
   logic [31:0] id_inst_d;
   logic        id_valid_d;
   logic        id_excp_d;

   // Sequential +4; wraps modulo 2^32 naturally.
   logic [31:0] pc_plus4;
   assign pc_plus4 = pc_q + 32'd4;

   // Alignment fault on the current fetch address. Only meaningful when the
   // check is compiled in; otherwise it is a constant 0.
   logic misaligned;
`ifdef IF_ALIGN_CHECK_EN
   assign misaligned = (pc_q[1:0] != 2'b00);
`else
   assign misaligned = 1'b0;
`endif

   // ------------------------------------------------------------------------
   // Next PC and pending-branch register
   // ------------------------------------------------------------------------
   always_comb begin
      pc_d          = pc_q;
      pend_valid_d  = pend_valid_q;
      pend_target_d = pend_target_q;

      if (!rom_ce_q) begin
         // ROM not yet enabled: sit at the reset vector with nothing pending.
         pc_d          = RESET_PC;
         pend_valid_d  = 1'b0;
         pend_target_d = 32'h0000_0000;
      end else if (flush) begin
         // Redirect drops any branch remembered during a stall.
         pc_d          = new_pc;
         pend_valid_d  = 1'b0;
         pend_target_d = 32'h0000_0000;
      end else if (stall_pc) begin
         // PC holds; a branch resolved now must not be lost, so remember it
         // (a later one in the same stall replaces an earlier one).
         pc_d = pc_q;
         if (branch_flag) begin
            pend_valid_d  = 1'b1;
            pend_target_d = branch_target;
         end
      end else begin
         // First free edge: a live branch is newer than the pending one.
         if (branch_flag) begin
            pc_d = branch_target;
         end else if (pend_valid_q) begin
            pc_d = pend_target_q;
         end else begin
            pc_d = pc_plus4;
         end
         pend_valid_d  = 1'b0;
         pend_target_d = 32'h0000_0000;
      end
   end

   // ------------------------------------------------------------------------
   // IF/ID register next state
   // ------------------------------------------------------------------------
   always_comb begin
      // Default: bubble
      id_pc_d    = 32'h0000_0000;
      id_inst_d  = 32'h0000_0000;
      id_valid_d = 1'b0;
      id_excp_d  = 1'b0;

      if (!rom_ce_q || flush) begin
         // bubble (defaults)
      end else if (!stall_pc) begin
         id_pc_d    = pc_q;
         id_valid_d = 1'b1;
         if (misaligned) begin
            // Poisoned entry: do not pass the garbage word downstream.
            id_inst_d = 32'h0000_0000;
            id_excp_d = 1'b1;
         end else begin
            id_inst_d = rom_inst;
            id_excp_d = 1'b0;
         end
      end else if (stall_id) begin
         id_pc_d    = id_pc_q;
         id_inst_d  = id_inst_q;
         id_valid_d = id_valid_q;
         id_excp_d  = id_excp;
      end else begin
         // stall_pc=1, stall_id=0: ID drains, IF has nothing new -> bubble
      end
   end

   // ------------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc_q          <= RESET_PC;
         rom_ce_q      <= 1'b0;
         pend_valid_q  <= 1'b0;
         pend_target_q <= 32'h0000_0000;
      end else begin
         pc_q          <= pc_d;
         rom_ce_q      <= 1'b1;
         pend_valid_q  <= pend_valid_d;
         pend_target_q <= pend_target_d;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         id_pc_q    <= 32'h0000_0000;
         id_inst_q  <= 32'h0000_0000;
         id_valid_q <= 1'b0;
      end else begin
         id_pc_q    <= id_pc_d;
         id_inst_q  <= id_inst_d;
         id_valid_q <= id_valid_d;
      end
   end

`ifdef IF_ALIGN_CHECK_EN
   logic id_excp_q;
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         id_excp_q <= 1'b0;
      end else begin
         id_excp_q <= id_excp_d;
      end
   end
   assign id_excp = id_excp_q;
`else
   // Without the check the flag never sets; the next-state term is always 0.
   logic unused_excp;
   assign unused_excp = id_excp_d;
   assign id_excp     = 1'b0;
`endif

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   assign pc       = pc_q;
   assign rom_ce   = rom_ce_q;
   assign id_pc    = id_pc_q;
   assign id_inst  = id_inst_q;
   assign id_valid = id_valid_q;

endmodule

// File: tb/tb_if_stage.sv
// ---------------------------------------------------------------------------
// tb_if_stage -- directed testbench for if_stage
//
// A combinational ROM model answers every pc with inst_of(pc). Each step
// advances one rising edge, waits 1 ns, and compares the full visible state
// against hand-computed values.
// ---------------------------------------------------------------------------
module tb_if_stage;

   // ------------------------------------------------------------------------
   // Clock / reset
   // ------------------------------------------------------------------------
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        stall_pc = 1'b0;
   logic        stall_id = 1'b0;
   logic        flush = 1'b0;
   logic [31:0] new_pc = 32'h0;
   logic        branch_flag = 1'b0;
   logic [31:0] branch_target = 32'h0;
   logic [31:0] pc;
   logic        rom_ce;
   logic [31:0] rom_inst;
   logic [31:0] id_pc;
   logic [31:0] id_inst;
   logic        id_valid;
   logic        id_excp;

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // ROM model: distinct, address-derived word for every fetch address
   function automatic logic [31:0] inst_of(input logic [31:0] a);
      return {~a[15:0], a[15:0]} ^ 32'h1357_9BDF;
   endfunction

   assign rom_inst = inst_of(pc);

   if_stage #(.RESET_PC(32'h0000_0000)) dut (
      .clk          (clk),
      .rst          (rst),
      .stall_pc     (stall_pc),
      .stall_id     (stall_id),
      .flush        (flush),
      .new_pc       (new_pc),
      .branch_flag  (branch_flag),
      .branch_target(branch_target),
      .pc           (pc),
      .rom_ce       (rom_ce),
      .rom_inst     (rom_inst),
      .id_pc        (id_pc),
      .id_inst      (id_inst),
      .id_valid     (id_valid),
      .id_excp      (id_excp)
   );

   // ------------------------------------------------------------------------
   // Driver / checker tasks
   // ------------------------------------------------------------------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic sp, input logic si, input logic fl,
                        input logic [31:0] npc, input logic br,
                        input logic [31:0] bt);
      stall_pc      = sp;
      stall_id      = si;
      flush         = fl;
      new_pc        = npc;
      branch_flag   = br;
      branch_target = bt;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Full-state comparison: ce, pc, and the IF/ID entry
   task automatic chk_state(input string tag, input logic ce,
                            input logic [31:0] e_pc, input logic [31:0] e_id_pc,
                            input logic [31:0] e_id_inst, input logic e_valid,
                            input logic e_excp);
      chk({tag, ".rom_ce"},   {31'b0, rom_ce},   {31'b0, ce});
      chk({tag, ".pc"},       pc,                e_pc);
      chk({tag, ".id_pc"},    id_pc,             e_id_pc);
      chk({tag, ".id_inst"},  id_inst,           e_id_inst);
      chk({tag, ".id_valid"}, {31'b0, id_valid}, {31'b0, e_valid});
      chk({tag, ".id_excp"},  {31'b0, id_excp},  {31'b0, e_excp});
   endtask

   // ------------------------------------------------------------------------
   // Directed sequence
   // ------------------------------------------------------------------------
   initial begin
      #2;
      chk_state("reset", 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);

      @(negedge clk);
      rst = 1'b1;

      // Reset release, free running fetch 0,4,8,C
      step(); chk_state("rel_e1", 1'b1, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
      step(); chk_state("seq_4",  1'b1, 32'h4, 32'h0, inst_of(32'h0), 1'b1, 1'b0);
      step(); chk_state("seq_8",  1'b1, 32'h8, 32'h4, inst_of(32'h4), 1'b1, 1'b0);
      step(); chk_state("seq_c",  1'b1, 32'hC, 32'h8, inst_of(32'h8), 1'b1, 1'b0);

      // Return to pc=8 via flush, then branch to 0x100 with delay slot at 8
      drive(1'b0, 1'b0, 1'b1, 32'h8, 1'b0, 32'h0);
      step(); chk_state("fl_8",   1'b1, 32'h8, 32'h0, 32'h0, 1'b0, 1'b0);
      drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h100);
      step(); chk_state("br_100", 1'b1, 32'h100, 32'h8, inst_of(32'h8), 1'b1, 1'b0);
      drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      step(); chk_state("br_104", 1'b1, 32'h104, 32'h100, inst_of(32'h100), 1'b1, 1'b0);

      // 3-cycle PC stall (ID held), branch pulsed in cycle 2 -> 0x200 once
      drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
      step(); chk_state("st_c1",  1'b1, 32'h104, 32'h100, inst_of(32'h100), 1'b1, 1'b0);
      drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h200);
      step(); chk_state("st_c2",  1'b1, 32'h104, 32'h100, inst_of(32'h100), 1'b1, 1'b0);
      drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
      step(); chk_state("st_c3",  1'b1, 32'h104, 32'h100, inst_of(32'h100), 1'b1, 1'b0);
      drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      step(); chk_state("pend_200", 1'b1, 32'h200, 32'h104, inst_of(32'h104), 1'b1, 1'b0);
      step(); chk_state("pend_204", 1'b1, 32'h204, 32'h200, inst_of(32'h200), 1'b1, 1'b0);

      // Flush during full stall with a pending branch
      drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h300);
      step(); chk_state("fp_pend", 1'b1, 32'h204, 32'h200, inst_of(32'h200), 1'b1, 1'b0);
      drive(1'b1, 1'b1, 1'b1, 32'h180, 1'b0, 32'h0);
      step(); chk_state("fp_180",  1'b1, 32'h180, 32'h0, 32'h0, 1'b0, 1'b0);
      drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      step(); chk_state("fp_184",  1'b1, 32'h184, 32'h180, inst_of(32'h180), 1'b1, 1'b0);
      step(); chk_state("fp_188",  1'b1, 32'h188, 32'h184, inst_of(32'h184), 1'b1, 1'b0);

      // One cycle stall_pc=1, stall_id=0 -> exactly one bubble
      drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      step(); chk_state("bub",     1'b1, 32'h188, 32'h0, 32'h0, 1'b0, 1'b0);
      drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      step(); chk_state("bub_nxt", 1'b1, 32'h18C, 32'h188, inst_of(32'h188), 1'b1, 1'b0);

      // Live branch on the release edge overrides the pending one
      drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h400);
      step(); chk_state("ov_pend", 1'b1, 32'h18C, 32'h188, inst_of(32'h188), 1'b1, 1'b0);
      drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h500);
      step(); chk_state("ov_500",  1'b1, 32'h500, 32'h18C, inst_of(32'h18C), 1'b1, 1'b0);
      drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      step(); chk_state("ov_504",  1'b1, 32'h504, 32'h500, inst_of(32'h500), 1'b1, 1'b0);

      // pc+4 wraps
      drive(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0);
      step(); chk_state("wr_top",  1'b1, 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b0, 1'b0);
      drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      step(); chk_state("wr_zero", 1'b1, 32'h0, 32'hFFFF_FFFC, inst_of(32'hFFFF_FFFC), 1'b1, 1'b0);
      step(); chk_state("wr_4",    1'b1, 32'h4, 32'h0, inst_of(32'h0), 1'b1, 1'b0);

      // Reset asserted mid-stall with a pending branch
      drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h600);
      step(); chk_state("rs_pend", 1'b1, 32'h4, 32'h0, inst_of(32'h0), 1'b1, 1'b0);
      #2;
      rst = 1'b0;
      #1;
      chk_state("rs_async", 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
      drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      @(negedge clk);
      rst = 1'b1;
      step(); chk_state("rs_e1", 1'b1, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
      step(); chk_state("rs_4",  1'b1, 32'h4, 32'h0, inst_of(32'h0), 1'b1, 1'b0);

      // Branch to a misaligned target
      drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h102);
      step(); chk_state("mis_br", 1'b1, 32'h102, 32'h4, inst_of(32'h4), 1'b1, 1'b0);
      drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      step();
`ifdef IF_ALIGN_CHECK_EN
      chk_state("mis_cap", 1'b1, 32'h106, 32'h102, 32'h0, 1'b1, 1'b1);
`else
      chk_state("mis_cap", 1'b1, 32'h106, 32'h102, inst_of(32'h102), 1'b1, 1'b0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
- REQ-001: The block SHALL have parameter RESET_PC, default 32'h0000_0000, which is the first fetch address after reset.
- REQ-002: The block SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
- REQ-003: The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
- REQ-004: The block SHALL have port stall_pc, input, 1 bit: hold PC (IF stalled).
- REQ-005: The block SHALL have port stall_id, input, 1 bit: hold the IF/ID register (ID stalled).
- REQ-006: The block SHALL have port flush, input, 1 bit: exception/eret redirect.
- REQ-007: The block SHALL have port new_pc, input, 32 bits: redirect address, used when flush=1.
- REQ-008: The block SHALL have port branch_flag, input, 1 bit: ID resolved a taken branch.
- REQ-009: The block SHALL have port branch_target, input, 32 bits: taken-branch address.
- REQ-010: The block SHALL have port pc, output, 32 bits: fetch address to the instruction ROM.
- REQ-011: The block SHALL have port rom_ce, output, 1 bit: ROM chip enable; 1 = enabled.
- REQ-012: The block SHALL have port rom_inst, input, 32 bits: combinational ROM data for the current pc.
- REQ-013: The block SHALL have port id_pc, output, 32 bits: PC of the instruction in the IF/ID register.
- REQ-014: The block SHALL have port id_inst, output, 32 bits: instruction word in the IF/ID register.
- REQ-015: The block SHALL have port id_valid, output, 1 bit: IF/ID holds a real instruction.
- REQ-016: The block SHALL have port id_excp, output, 1 bit: fetch address error flag (see Configuration).

Function
- REQ-017: rom_ce SHALL be registered: 0 in reset, 1 from the first rising edge after rst deasserts; pc SHALL stay RESET_PC while rom_ce=0.
- REQ-018: Next-pc priority while rom_ce=1 SHALL be flush > stall_pc > taken branch (live or pending) > pc+4.
- REQ-019: On flush=1, pc SHALL load new_pc, the pending-branch register SHALL clear, and IF/ID SHALL load a bubble, regardless of stall_pc and stall_id.
- REQ-020: On stall_pc=1 with no flush, pc SHALL hold; a branch_flag=1 seen during the stall SHALL be latched with its target into a 1-entry pending-branch register.
- REQ-021: On the first non-stalled edge, the pending branch SHALL load pc and clear; a live branch_flag on that same edge SHALL override the pending target.
- REQ-022: Branches SHALL have one delay slot: the instruction being fetched while branch_flag=1 SHALL enter IF/ID normally.
- REQ-023: pc+4 SHALL wrap modulo 2^32, so 32'hFFFF_FFFC becomes 32'h0000_0000.
- REQ-024: IF/ID update SHALL follow these rules:
  - flush: bubble.
  - stall_pc=0: capture {pc, rom_inst, valid=1}.
  - stall_pc=1, stall_id=1: hold.
  - stall_pc=1, stall_id=0: bubble.
- REQ-025: A bubble SHALL be id_pc=0, id_inst=0, id_valid=0, id_excp=0.
- REQ-026: While rom_ce=0, IF/ID SHALL load bubbles.
- REQ-027: id_* outputs SHALL be registered: one-cycle latency from pc to id_pc.

Reset
- REQ-028: While rst=0, the block SHALL immediately (asynchronously) set:
  - pc=RESET_PC, rom_ce=0;
  - pending branch cleared;
  - id_pc=0, id_inst=0, id_valid=0, id_excp=0.
- REQ-029: Reset asserted mid-stall or mid-pending-branch SHALL discard all pending state; fetch SHALL restart at RESET_PC.

Configuration
- REQ-030: With macro IF_ALIGN_CHECK_EN defined, a capture where pc[1:0]!=0 SHALL load id_inst=0, id_pc=pc, id_valid=1, id_excp=1.
- REQ-031: With IF_ALIGN_CHECK_EN defined, pc SHALL then advance normally, and the downstream exception logic SHALL redirect via flush.
- REQ-032: Without IF_ALIGN_CHECK_EN, id_excp SHALL be constant 0 and pc[1:0] SHALL be ignored.

Verification
- REQ-033: Reset release, no stalls -> rom_ce=1 after one edge; pc sequence 0,4,8,C; id_pc trails pc by one cycle with id_valid=1.
- REQ-034: branch_flag=1, target 32'h100, at pc=8 -> delay slot at 8 enters IF/ID; next pc=0x100.
- REQ-035: stall_pc=1 for 3 cycles with branch_flag pulsed in cycle 2 (target 0x200) -> pc held; on release pc=0x200 exactly once; then 0x204.
- REQ-036: flush=1 with new_pc=32'h180 while stall_pc=stall_id=1 and a branch pending -> pc=0x180; IF/ID bubble; pending branch dropped.
- REQ-037: stall_pc=1, stall_id=0 for 1 cycle -> one bubble (id_valid=0, id_inst=0), no duplicated or lost instruction.
- REQ-038: pc=32'hFFFF_FFFC, no stall -> next pc=0; with IF_ALIGN_CHECK_EN, branch to 32'h102 -> id_excp=1, id_inst=0, id_pc=32'h102.
